// File: rtl/systolic_pkg.sv
// Shared sizing and types for the 4x4 output-stationary systolic array.
// The sizes are fixed by the 32/128-bit port widths of systolic_array_4x4.
package systolic_pkg;

  localparam int N      = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 8;
  localparam int PROD_W = 2 * DATA_W;
  localparam int IN_W   = N * DATA_W;
  localparam int BUS_W  = N * N * ACC_W;

  typedef logic [DATA_W-1:0] operand_t;
  typedef logic [ACC_W-1:0]  acc_t;
  typedef logic [PROD_W-1:0] prod_t;
  // One extra bit so that acc + product never overflows before truncation or clamping.
  typedef logic [PROD_W:0]   sum_t;

endpackage

// File: rtl/systolic_pe.sv
// One processing element: registers A/B for the right/down neighbours and accumulates a_in*b_in every edge.
// Define SYSTOLIC_SAT_EN to clamp the accumulator at 255; the default build wraps modulo 256.
module systolic_pe
  import systolic_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  operand_t a_in,
  input  operand_t b_in,
  output operand_t a_out,
  output operand_t b_out,
  output acc_t     acc
);

  operand_t a_q;
  operand_t b_q;
  acc_t     acc_q;
  acc_t     acc_d;
  prod_t    prod;
  sum_t     sum;

  always_comb begin
    prod = prod_t'(a_in) * prod_t'(b_in);
    sum  = sum_t'(acc_q) + sum_t'(prod);
`ifdef SYSTOLIC_SAT_EN
    // Once at 255, sum can never drop below 255, so a saturated PE holds until reset.
    acc_d = (sum > sum_t'({ACC_W{1'b1}})) ? {ACC_W{1'b1}} : acc_t'(sum);
`else
    acc_d = acc_t'(sum);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_in;
      b_q   <= b_in;
      acc_q <= acc_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_array_4x4.sv
// 4x4 output-stationary systolic array: A enters per row on the left, B per column on the top, 16 accumulators out.
// No handshake; accumulators are driven straight onto macout. SYSTOLIC_SAT_EN selects saturating accumulation.
module systolic_array_4x4
  import systolic_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [IN_W-1:0]   datain,
  input  logic [IN_W-1:0]   weightin,
  output logic [BUS_W-1:0]  macout
);

  // a_link[r][c] is the registered A of PE(r,c) feeding PE(r,c+1); b_link likewise downward.
  operand_t a_link   [N][N-1];
  operand_t b_link   [N-1][N];
  operand_t a_unused [N];
  operand_t b_unused [N];

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      operand_t a_in_w;
      operand_t b_in_w;
      acc_t     acc_w;

      if (c == 0) begin : g_a_edge
        assign a_in_w = datain[IN_W-1-DATA_W*r -: DATA_W];
      end else begin : g_a_link
        assign a_in_w = a_link[r][c-1];
      end

      if (r == 0) begin : g_b_edge
        assign b_in_w = weightin[IN_W-1-DATA_W*c -: DATA_W];
      end else begin : g_b_link
        assign b_in_w = b_link[r-1][c];
      end

      if (c == N - 1) begin : g_pe_last_col
        if (r == N - 1) begin : g_corner
          systolic_pe u_pe (
            .clk   (clk),
            .reset (reset),
            .a_in  (a_in_w),
            .b_in  (b_in_w),
            .a_out (a_unused[r]),
            .b_out (b_unused[c]),
            .acc   (acc_w)
          );
        end else begin : g_right
          systolic_pe u_pe (
            .clk   (clk),
            .reset (reset),
            .a_in  (a_in_w),
            .b_in  (b_in_w),
            .a_out (a_unused[r]),
            .b_out (b_link[r][c]),
            .acc   (acc_w)
          );
        end
      end else begin : g_pe_inner_col
        if (r == N - 1) begin : g_bottom
          systolic_pe u_pe (
            .clk   (clk),
            .reset (reset),
            .a_in  (a_in_w),
            .b_in  (b_in_w),
            .a_out (a_link[r][c]),
            .b_out (b_unused[c]),
            .acc   (acc_w)
          );
        end else begin : g_inner
          systolic_pe u_pe (
            .clk   (clk),
            .reset (reset),
            .a_in  (a_in_w),
            .b_in  (b_in_w),
            .a_out (a_link[r][c]),
            .b_out (b_link[r][c]),
            .acc   (acc_w)
          );
        end
      end

      // PE(0,0) occupies the most significant byte of macout.
      assign macout[BUS_W-1-ACC_W*(N*r+c) -: ACC_W] = acc_w;
    end
  end

endmodule

// File: tb/tb_systolic_array_4x4.sv
// Directed bench for systolic_array_4x4: expectations are queued as stimulus is driven and checked after each edge.
module tb_systolic_array_4x4;

  logic         clk;
  logic         reset;
  logic [31:0]  datain;
  logic [31:0]  weightin;
  logic [127:0] macout;

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_q [$];
  string        tag_q [$];

  int a_mat [4][4];
  int b_mat [4][4];

  systolic_array_4x4 dut (
    .clk      (clk),
    .reset    (reset),
    .datain   (datain),
    .weightin (weightin),
    .macout   (macout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [127:0] pe_val(int r, int c, int v);
    logic [127:0] x;
    x = '0;
    x[127-8*(4*r+c) -: 8] = v[7:0];
    return x;
  endfunction

  // Expected grid after feed step t: operand index k reaches PE(r,c) on step r+c+k.
  function automatic logic [127:0] mat_expect(int t);
    logic [127:0] x;
    int s;
    x = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        s = 0;
        for (int k = 0; k < 4; k++)
          if (r + c + k <= t) s += a_mat[r][k] * b_mat[k][c];
        x[127-8*(4*r+c) -: 8] = s[7:0];
      end
    return x;
  endfunction

  task automatic push_exp(input logic [127:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_pop();
    logic [127:0] e;
    string tag;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed=%h expected=<entry>", macout);
      return;
    end
    e   = exp_q.pop_front();
    tag = tag_q.pop_front();
    checks++;
    assert (macout === e) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, macout, e);
    end
  endtask

  // Inputs are changed 1 time unit after a rising edge and sampled 1 unit after the next.
  task automatic step(input logic [31:0] d, input logic [31:0] w, input logic [127:0] e, input string tag);
    datain   = d;
    weightin = w;
    push_exp(e, tag);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  task automatic do_reset();
    datain   = '0;
    weightin = '0;
    reset    = 1'b0;
    #1;
    push_exp('0, "reset_clear");
    check_pop();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic run_matrix(input int last_t, input string tag);
    logic [31:0] d;
    logic [31:0] w;
    for (int t = 0; t <= last_t; t++) begin
      d = '0;
      w = '0;
      for (int i = 0; i < 4; i++) begin
        if (t - i >= 0 && t - i < 4) begin
          d[31-8*i -: 8] = a_mat[i][t-i][7:0];
          w[31-8*i -: 8] = b_mat[t-i][i][7:0];
        end
      end
      step(d, w, mat_expect(t), tag);
    end
  endtask

  initial begin
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        a_mat[r][c] = 4 * r + c + 1;
        b_mat[r][c] = (r == c) ? 1 : 0;
      end

    // Reset held low while inputs toggle
    reset    = 1'b0;
    datain   = 32'hFFFF_FFFF;
    weightin = 32'hFFFF_FFFF;
    #1;
    push_exp('0, "reset_initial");
    check_pop();
    step(32'hFFFF_FFFF, 32'h1234_5678, '0, "reset_held_a");
    step(32'hA5A5_A5A5, 32'hFFFF_FFFF, '0, "reset_held_b");
    datain   = '0;
    weightin = '0;
    reset    = 1'b1;
    for (int i = 0; i < 3; i++) step('0, '0, '0, "post_reset_idle");

    // Single MAC into PE(0,0)
    step(32'h0200_0000, 32'h0300_0000, pe_val(0, 0, 6), "single_mac");
    for (int i = 0; i < 6; i++) step('0, '0, pe_val(0, 0, 6), "single_mac_stable");
    do_reset();

    // A reaches PE(0,1) one edge late and meets the weight entering column 1
    step(32'h0100_0000, 32'h0000_0000, '0, "prop_a_only");
    step(32'h0000_0000, 32'h0005_0000, pe_val(0, 1, 5), "prop_meet");
    for (int i = 0; i < 5; i++) step('0, '0, pe_val(0, 1, 5), "prop_stable");
    do_reset();

    // A (1..16) times identity, skewed feed plus settling
    run_matrix(13, "matrix_step");
    push_exp(128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10, "matrix_result");
    check_pop();
    do_reset();

    // Accumulator overflow
`ifdef SYSTOLIC_SAT_EN
    step(32'h1000_0000, 32'h1000_0000, pe_val(0, 0, 255), "ovf_first");
    step(32'h1000_0000, 32'h1000_0000, pe_val(0, 0, 255), "ovf_second");
    step('0, '0, pe_val(0, 0, 255), "ovf_hold");
`else
    step(32'h1000_0000, 32'h1000_0000, pe_val(0, 0, 0), "ovf_first");
    step(32'h1000_0000, 32'h1000_0000, pe_val(0, 0, 0), "ovf_second");
    step('0, '0, pe_val(0, 0, 0), "ovf_hold");
`endif
    do_reset();
    step(32'h1900_0000, 32'h0A00_0000, pe_val(0, 0, 250), "wrap_base");
`ifdef SYSTOLIC_SAT_EN
    step(32'h0100_0000, 32'h0A00_0000, pe_val(0, 0, 255), "wrap_260");
`else
    step(32'h0100_0000, 32'h0A00_0000, pe_val(0, 0, 4), "wrap_260");
`endif
    do_reset();

    // Reset pulsed mid-matrix clears without waiting for an edge
    run_matrix(3, "midrun_pre");
    #2;
    reset = 1'b0;
    #1;
    push_exp('0, "midrun_async_clear");
    check_pop();
    @(posedge clk);
    #1;
    push_exp('0, "midrun_held");
    check_pop();
    reset = 1'b1;
    step('0, '0, '0, "midrun_release");
    run_matrix(13, "midrun_restart");

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover: observed=%0d entries expected=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
